// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants and receiver state encoding.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;
    localparam int UART_DATA_BITS = 8;
    localparam logic PARITY_ODD = 1'b0;
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } rx_state_e;
endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchronizer for one asynchronous bit, with a configurable reset value.
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic [1:0] ff_q, ff_d;
    always_comb ff_d = {ff_q[0], d};
    always_ff @(posedge clock) begin
        if (reset) ff_q <= {2{RESET_VAL}};
        else       ff_q <= ff_d;
    end
    assign q = ff_q[1];
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with break detection; defining UART_RX_PARITY_EN adds one even-parity bit.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);
    localparam logic [15:0] HALF = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL = 16'(CLKS_PER_BIT - 1);
`ifdef UART_RX_PARITY_EN
    localparam rx_state_e AFTER_DATA = ST_PARITY;
`else
    localparam rx_state_e AFTER_DATA = ST_STOP;
`endif
    logic                      rx_s, tick, par_bad;
    rx_state_e                 state_q, state_d;
    logic [15:0]               cnt_q, cnt_d;
    logic [2:0]                bit_q, bit_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
    logic                      valid_q, valid_d, ferr_q, ferr_d, perr_q, perr_d;
    uart_sync2 #(.RESET_VAL(1'b1)) u_sync (.clock(clock), .reset(reset), .d(rx), .q(rx_s));
    assign tick = cnt_q == 16'd0;
`ifdef UART_RX_PARITY_EN
    logic par_q, par_d;
    assign par_bad = (^shift_q ^ par_q) != PARITY_ODD;
`else
    assign par_bad = 1'b0;
`endif
    always_comb begin
        state_d = state_q;
        cnt_d   = tick ? FULL : cnt_q - 16'd1;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        perr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            ST_IDLE: begin
                cnt_d = rx_s ? 16'd0 : HALF;
                bit_d = 3'd0;
                if (!rx_s) state_d = ST_START;
            end
            ST_START: if (tick) state_d = rx_s ? ST_IDLE : ST_DATA;
            ST_DATA: if (tick) begin
                shift_d = {rx_s, shift_q[UART_DATA_BITS-1:1]};
                bit_d   = bit_q + 3'd1;
                if (bit_q == 3'(UART_DATA_BITS - 1)) state_d = AFTER_DATA;
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: if (tick) begin
                par_d   = rx_s;
                state_d = ST_STOP;
            end
`endif
            ST_STOP: if (tick) begin
                data_d  = shift_q;
                valid_d = rx_s & ~par_bad;
                ferr_d  = ~rx_s;
                perr_d  = rx_s & par_bad;
                state_d = rx_s ? ST_IDLE : ST_BREAK;
            end
            ST_BREAK: begin
                cnt_d = 16'd0;
                if (rx_s) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 16'd0;
            bit_q   <= 3'd0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            perr_q  <= perr_d;
        end
    end
`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clock) begin
        if (reset) par_q <= 1'b0;
        else       par_q <= par_d;
    end
`endif
    assign data       = data_q;
    assign valid      = valid_q;
    assign frame_err  = ferr_q;
    assign parity_err = perr_q;
    assign busy       = state_q != ST_IDLE;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx; instance 0 runs at 16 clocks/bit, instance 1 at 4 clocks/bit.
module tb_uart_rx;
`ifdef UART_RX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    typedef struct {
        int          kind;
        logic [7:0]  data;
        longint      cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_i [2];
    logic [7:0] data_o [2];
    logic       valid_o [2];
    logic       ferr_o [2];
    logic       perr_o [2];
    logic       busy_o [2];
    logic       prev_p [2];
    exp_t       sb [2][$];
    longint     cyc = 0;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        uart_rx #(.CLKS_PER_BIT(g == 0 ? 16 : 4)) dut (
            .clock(clk), .reset(reset), .rx(rx_i[g]), .data(data_o[g]), .valid(valid_o[g]),
            .frame_err(ferr_o[g]), .parity_err(perr_o[g]), .busy(busy_o[g])
        );
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int cpb(input int u);
        return u == 0 ? 16 : 4;
    endfunction

    task automatic bit_out(input int u, input logic v, input int n);
        rx_i[u] = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference: stop low wins, then even-parity check, else good byte; data is always the sent byte.
    task automatic send_frame(input int u, input logic [7:0] b, input logic stop, input logic pbit);
        exp_t e;
        int c;
        c = cpb(u);
        e.kind = !stop ? 1 : (PB == 1 && (^b) != pbit) ? 2 : 0;
        e.data = b;
        e.cyc  = cyc + 3 + c / 2 + (9 + PB) * c;
        sb[u].push_back(e);
        bit_out(u, 1'b0, c);
        for (int i = 0; i < 8; i++) bit_out(u, b[i], c);
        if (PB == 1) bit_out(u, pbit, c);
        bit_out(u, stop, c);
    endtask

    task automatic check_busy(input string name, input logic exp);
        @(negedge clk);
        chk(name, busy_o[0], exp);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        int   n;
        int   kind;
        exp_t e;
        for (int u = 0; u < 2; u++) begin
            n = int'(valid_o[u]) + int'(ferr_o[u]) + int'(perr_o[u]);
            if (n != 0) begin
                chk($sformatf("exclusive%0d", u), n, 1);
                chk($sformatf("pulse_width%0d", u), prev_p[u], 0);
                kind = valid_o[u] ? 0 : ferr_o[u] ? 1 : 2;
                if (sb[u].size() == 0) chk($sformatf("unexpected_pulse%0d", u), sb[u].size(), 1);
                else begin
                    e = sb[u].pop_front();
                    chk($sformatf("kind%0d", u), kind, e.kind);
                    chk($sformatf("data%0d", u), data_o[u], e.data);
                    chk($sformatf("latency%0d", u), cyc, e.cyc);
                end
            end
            prev_p[u] = n != 0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] b;
        logic       stop, pbit;
        int         w;
        prev_p = '{1'b0, 1'b0};
        rx_i   = '{1'b1, 1'b1};
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_data", data_o[0], 8'h00);
        chk("rst_valid", valid_o[0], 0);
        chk("rst_ferr", ferr_o[0], 0);
        chk("rst_perr", perr_o[0], 0);
        chk("rst_busy", busy_o[0], 0);
        @(posedge clk);
        #1 reset = 1'b0;
        bit_out(0, 1'b1, 5);
        send_frame(0, 8'hA5, 1'b1, 1'b0);
        bit_out(0, 1'b1, 20);
        bit_out(0, 1'b0, 4);
        bit_out(0, 1'b1, 30);
        check_busy("glitch_busy", 1'b0);
        send_frame(0, 8'h3C, 1'b1, 1'b0);
        bit_out(0, 1'b1, 10);
        send_frame(0, 8'h81, 1'b0, 1'b0);
        bit_out(0, 1'b0, 20);
        check_busy("break_busy", 1'b1);
        bit_out(0, 1'b0, 19);
        bit_out(0, 1'b1, 6);
        check_busy("break_exit_busy", 1'b0);
        send_frame(0, 8'h55, 1'b1, 1'b0);
        bit_out(0, 1'b1, 10);
        if (PB == 1) begin
            send_frame(0, 8'h07, 1'b1, 1'b0);
            bit_out(0, 1'b1, 10);
            send_frame(0, 8'h07, 1'b1, 1'b1);
            bit_out(0, 1'b1, 10);
        end
        bit_out(0, 1'b0, 16);
        bit_out(0, 1'b1, 16 * 3 + 8);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("midrst_data", data_o[0], 8'h00);
        chk("midrst_valid", valid_o[0], 0);
        chk("midrst_ferr", ferr_o[0], 0);
        chk("midrst_perr", perr_o[0], 0);
        chk("midrst_busy", busy_o[0], 0);
        @(posedge clk);
        #1;
        bit_out(0, 1'b1, 48);
        send_frame(0, 8'hC3, 1'b1, 1'b0);
        bit_out(0, 1'b1, 5);
        for (int k = 0; k < 40; k++) begin
            b    = 8'($urandom);
            stop = $urandom_range(0, 7) != 0;
            pbit = (^b) ^ ($urandom_range(0, 3) == 0);
            send_frame(0, b, stop, pbit);
            if (!stop) bit_out(0, 1'b0, $urandom_range(0, 30));
            bit_out(0, 1'b1, stop ? $urandom_range(0, 20) : $urandom_range(3, 20));
        end
        bit_out(1, 1'b1, 4);
        send_frame(1, 8'h00, 1'b1, 1'b0);
        send_frame(1, 8'hFF, 1'b1, 1'b0);
        bit_out(1, 1'b1, 4);
        w = 0;
        while ((sb[0].size() != 0 || sb[1].size() != 0) && w < 2000) begin
            @(posedge clk);
            w++;
        end
        repeat (4) @(posedge clk);
        chk("drain0", sb[0].size(), 0);
        chk("drain1", sb[1].size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, clock cycles per serial bit; legal range 4..65535.
REQ-002 clock  input  1  single clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 rx  input  1  asynchronous serial line; idle high; 8N1, LSB first.
REQ-005 data  output  8  last received byte; holds until next frame completes.
REQ-006 valid  output  1  one-cycle pulse: data holds a good byte.
REQ-007 frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-008 parity_err  output  1  one-cycle pulse: parity mismatch; constant 0 when parity is compiled out.
REQ-009 busy  output  1  high in every state except IDLE.

Function
REQ-010 rx SHALL pass through a 2-flop synchronizer (rx_s) before any use; both flops reset to 1.
REQ-011 States SHALL be IDLE, START, DATA, PARITY (only when compiled in), STOP and BREAK.
REQ-012 IDLE: rx_s==0 in cycle t0 -> START; clear the bit counter; t0 is the frame reference.
REQ-013 START: at t0+CLKS_PER_BIT/2 (integer division), rx_s==1 -> IDLE with no output pulse (glitch reject); rx_s==0 -> DATA.
REQ-014 DATA: sample bit i (0..7) at t0+CLKS_PER_BIT/2+(i+1)*CLKS_PER_BIT; shift in LSB first; after bit 7 -> PARITY or STOP.
REQ-015 PARITY: sample one bit, one CLKS_PER_BIT after bit 7; then -> STOP.
REQ-016 STOP: sample one CLKS_PER_BIT after the last data or parity bit.
REQ-017 Stop sample 1 -> load data; in the next cycle pulse valid, unless parity failed; -> IDLE.
REQ-018 Stop sample 0 -> load data; in the next cycle pulse frame_err, valid stays 0; -> BREAK.
REQ-019 Stop sample 1 with parity mismatch -> load data; in the next cycle pulse parity_err, valid stays 0; -> IDLE.
REQ-020 BREAK: stay until rx_s==1, then -> IDLE; no new start detection in BREAK.
REQ-021 IDLE SHALL accept a new start bit in the cycle immediately after leaving STOP (back-to-back frames).
REQ-022 valid, frame_err and parity_err SHALL be mutually exclusive and never high for more than one cycle.
REQ-023 Bit-period counter SHALL be 16 bits wide, SHALL NOT wrap within a frame, and SHALL be reloaded at each sample point.

Reset
REQ-024 Reset SHALL force: state IDLE; data 0x00; valid, frame_err, parity_err and busy 0; synchronizer flops 1; counters 0.
REQ-025 Reset mid-frame SHALL abandon the frame with no output pulse; the next start bit is detected normally after reset releases.

Configuration
REQ-026 UART_RX_PARITY_EN defined: one even-parity bit follows the data bits; its check drives parity_err.
REQ-027 UART_RX_PARITY_EN undefined: no PARITY state; STOP follows bit 7; parity_err tied 0; port list unchanged.

Structure
REQ-028 Package uart_pkg SHALL hold the rx state enum, UART_DATA_BITS=8 and the parity-sense constant; the transmitter shares it.
REQ-029 The synchronizer SHALL be sub-module uart_sync2 (1-bit, reset value parameter); everything else lives in uart_rx.

Verification (CLKS_PER_BIT=16 unless stated)
REQ-030 Frame 0xA5 with good stop -> data=0xA5, valid one cycle at t0+8+9*16+1, no error pulse.
REQ-031 rx low for 4 clocks, then high -> no pulse, busy returns 0, next frame 0x3C received correctly.
REQ-032 Frame 0x81 with stop bit low, line held low 40 clocks -> frame_err one cycle, valid 0, state BREAK until line high; next 0x55 received.
REQ-033 UART_RX_PARITY_EN, 0x07 with parity bit 0 -> parity_err one cycle, valid 0; 0x07 with parity bit 1 -> valid, data=0x07.
REQ-034 Back-to-back 0x00 then 0xFF, no idle gap, CLKS_PER_BIT=4 -> two valid pulses, data 0x00 then 0xFF.
REQ-035 reset asserted one cycle during DATA bit 3 -> all outputs 0 next cycle, no pulse; following 0xC3 frame received.
